// File: rtl/mem_pkg.sv
// Shared widths, depth and encodings for the mem_responder memory slave.
package mem_pkg;

  localparam int unsigned ADR_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Latched CPU operation; OP_ERR marks a request with rd_mem and wr_mem both set.
  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_ERR
  } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the CPU bus and preload signals seen by mem_responder.
interface mem_responder_if;

  logic [mem_pkg::ADR_W-1:0]  adr_bus;
  logic                       rd_mem;
  logic                       wr_mem;
  logic [mem_pkg::DATA_W-1:0] data_bus_out;
  logic [mem_pkg::DATA_W-1:0] data_bus_in;
  logic                       mem_ready;
  logic                       bus_err;
  logic                       clearing;
  logic                       load_valid;
  logic                       load_ready;
  logic [mem_pkg::ADR_W-1:0]  load_adr;
  logic [mem_pkg::DATA_W-1:0] load_data;

  modport master (
    output adr_bus, rd_mem, wr_mem, data_bus_out, load_valid, load_adr, load_data,
    input  data_bus_in, mem_ready, bus_err, clearing, load_ready
  );

  modport slave (
    input  adr_bus, rd_mem, wr_mem, data_bus_out, load_valid, load_adr, load_data,
    output data_bus_in, mem_ready, bus_err, clearing, load_ready
  );

endinterface

// File: rtl/mem_array.sv
// 64x8 single-port storage: synchronous write, combinational read on the same address.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[adr] <= wdata;
    end
  end

  assign rdata = mem_q[adr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory slave with post-reset clear sweep and an idle-time preload port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] data_bus_out,
  output logic [DATA_W-1:0] data_bus_in,
  output logic              mem_ready,
  output logic              bus_err,
  output logic              clearing,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADR_W-1:0]  load_adr,
  input  logic [DATA_W-1:0] load_data
);

  localparam state_e     RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [2:0] WAIT_LAST   = 3'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  op_e               op_q, op_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  op_e               req_op;
  logic              commit;
  op_e               cmt_op;
  logic              arr_we;
  logic [ADR_W-1:0]  arr_adr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  always_comb begin
    req_op = OP_RD;
    if (rd_mem && wr_mem) begin
      req_op = OP_ERR;
    end else if (wr_mem) begin
      req_op = OP_WR;
    end
  end

  // Single write port: the clear sweep, a committing CPU access and an accepted
  // load are mutually exclusive by state, so one mux picks the array address.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    op_d       = op_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    bus_err_d  = bus_err_q;
    commit     = 1'b0;
    cmt_op     = op_q;
    arr_we     = 1'b0;
    arr_adr    = adr_q;
    arr_wdata  = wdata_q;

    unique case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_adr   = clr_cnt_q;
        arr_wdata = '0;
        clr_cnt_d = clr_cnt_q + 6'd1;
        if (clr_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rd_mem || wr_mem) begin
          op_d    = req_op;
          adr_d   = adr_bus;
          wdata_d = data_bus_out;
          if (req_op == OP_ERR) begin
            bus_err_d = 1'b1;
          end
          if (WAIT_STATES == 0) begin
            // Zero wait states: the access commits on the sampling edge itself.
            state_d   = ST_DONE;
            commit    = 1'b1;
            cmt_op    = req_op;
            arr_adr   = adr_bus;
            arr_wdata = data_bus_out;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end
        end else if (load_valid) begin
          arr_we    = 1'b1;
          arr_adr   = load_adr;
          arr_wdata = load_data;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    if (commit && (cmt_op == OP_WR)) begin
      arr_we = 1'b1;
    end
  end

  assign rdata_d = (commit && (cmt_op == OP_RD)) ? arr_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      op_q       <= OP_RD;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Reset blocks every array write, which aborts an in-flight access.
  mem_array u_array (
    .clk   (clk),
    .we    (arr_we && !reset),
    .adr   (arr_adr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign data_bus_in = rdata_q;
  assign mem_ready   = (state_q == ST_DONE);
  assign bus_err     = bus_err_q;
  assign clearing    = (state_q == ST_CLEAR);
  assign load_ready  = (state_q == ST_IDLE) && !rd_mem && !wr_mem;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded random traffic on a 1-wait-state clearing instance, plus directed
// back-to-back and reset-abort checks on two other parameterisations.
module tb_mem_responder;

  localparam int unsigned WA = 1;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [64];
  logic [7:0]  exp_rd;
  logic        exp_err;

  mem_responder_if ifa ();
  mem_responder_if ifb ();
  mem_responder_if ifc ();

  mem_responder #(.WAIT_STATES(WA), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .reset(rst_a),
    .adr_bus(ifa.adr_bus), .rd_mem(ifa.rd_mem), .wr_mem(ifa.wr_mem),
    .data_bus_out(ifa.data_bus_out), .data_bus_in(ifa.data_bus_in),
    .mem_ready(ifa.mem_ready), .bus_err(ifa.bus_err), .clearing(ifa.clearing),
    .load_valid(ifa.load_valid), .load_ready(ifa.load_ready),
    .load_adr(ifa.load_adr), .load_data(ifa.load_data)
  );

  mem_responder #(.WAIT_STATES(0), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .reset(rst_b),
    .adr_bus(ifb.adr_bus), .rd_mem(ifb.rd_mem), .wr_mem(ifb.wr_mem),
    .data_bus_out(ifb.data_bus_out), .data_bus_in(ifb.data_bus_in),
    .mem_ready(ifb.mem_ready), .bus_err(ifb.bus_err), .clearing(ifb.clearing),
    .load_valid(ifb.load_valid), .load_ready(ifb.load_ready),
    .load_adr(ifb.load_adr), .load_data(ifb.load_data)
  );

  mem_responder #(.WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .reset(rst_c),
    .adr_bus(ifc.adr_bus), .rd_mem(ifc.rd_mem), .wr_mem(ifc.wr_mem),
    .data_bus_out(ifc.data_bus_out), .data_bus_in(ifc.data_bus_in),
    .mem_ready(ifc.mem_ready), .bus_err(ifc.bus_err), .clearing(ifc.clearing),
    .load_valid(ifc.load_valid), .load_ready(ifc.load_ready),
    .load_adr(ifc.load_adr), .load_data(ifc.load_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for instance A: every mem_ready pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (ifa.mem_ready) begin
        if (sbq.size() == 0) begin
          chk("a_unexpected_ready", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("a_ready_cycle", cyc, e.due);
          chk("a_data_bus_in", {24'd0, ifa.data_bus_in}, {24'd0, e.data});
          chk("a_bus_err", {31'd0, ifa.bus_err}, {31'd0, e.err});
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
        chk("a_missing_ready", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic a_idle();
    ifa.rd_mem = 1'b0; ifa.wr_mem = 1'b0; ifa.load_valid = 1'b0;
    ifa.adr_bus = '0; ifa.data_bus_out = '0; ifa.load_adr = '0; ifa.load_data = '0;
  endtask

  // Issue one CPU request to A in an idle cycle, optionally with a competing load.
  task automatic a_req(input logic rd, input logic wr, input logic [5:0] adr,
                       input logic [7:0] d, input logic lv);
    exp_t e;
    e.due = cyc + 1 + WA;
    if (rd && wr) exp_err = 1'b1;
    else if (wr) ref_mem[adr] = d;
    else exp_rd = ref_mem[adr];
    e.data = exp_rd;
    e.err  = exp_err;
    sbq.push_back(e);
    ifa.rd_mem = rd; ifa.wr_mem = wr; ifa.adr_bus = adr; ifa.data_bus_out = d;
    ifa.load_valid = lv; ifa.load_adr = 6'($urandom); ifa.load_data = 8'($urandom);
    #1;
    if (lv) chk("a_load_stalled", {31'd0, ifa.load_ready}, 0);
    @(negedge clk);
    for (int i = 0; i <= int'(WA); i++) begin
      ifa.rd_mem = 1'($urandom); ifa.wr_mem = 1'($urandom);
      ifa.adr_bus = 6'($urandom); ifa.data_bus_out = 8'($urandom);
      ifa.load_valid = 1'($urandom); ifa.load_adr = 6'($urandom); ifa.load_data = 8'($urandom);
      #1;
      chk("a_busy_load_ready", {31'd0, ifa.load_ready}, 0);
      @(negedge clk);
    end
    a_idle();
  endtask

  task automatic a_load(input logic [5:0] adr, input logic [7:0] d);
    ifa.load_valid = 1'b1; ifa.load_adr = adr; ifa.load_data = d;
    #1;
    chk("a_load_ready", {31'd0, ifa.load_ready}, 1);
    ref_mem[adr] = d;
    @(negedge clk);
    a_idle();
  endtask

  task automatic a_reset_check();
    chk("a_rst_clearing", {31'd0, ifa.clearing}, 1);
    chk("a_rst_ready", {31'd0, ifa.mem_ready}, 0);
    chk("a_rst_err", {31'd0, ifa.bus_err}, 0);
    chk("a_rst_data", {24'd0, ifa.data_bus_in}, 0);
    chk("a_rst_load_ready", {31'd0, ifa.load_ready}, 0);
  endtask

  initial begin
    int n;
    int op;
    n_tests = 0; n_fail = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    exp_rd = '0; exp_err = 1'b0;
    a_idle();
    ifb.rd_mem = 0; ifb.wr_mem = 0; ifb.adr_bus = '0; ifb.data_bus_out = '0;
    ifb.load_valid = 0; ifb.load_adr = '0; ifb.load_data = '0;
    ifc.rd_mem = 0; ifc.wr_mem = 0; ifc.adr_bus = '0; ifc.data_bus_out = '0;
    ifc.load_valid = 0; ifc.load_adr = '0; ifc.load_data = '0;
    repeat (2) @(negedge clk);
    a_reset_check();

    // Interrupted sweep, then a full one that must restart from address 0.
    rst_a = 1'b0;
    repeat (20) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    a_reset_check();
    rst_a = 1'b0;
    n = 0;
    while (ifa.clearing && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("a_clear_cycles", n, 64);
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

    a_req(1, 0, 6'h3F, 8'h00, 0);
    a_req(0, 1, 6'h12, 8'hA5, 0);
    a_req(1, 0, 6'h12, 8'h00, 0);
    a_req(1, 0, 6'h05, 8'h00, 1);
    a_load(6'h05, 8'h3C);
    a_req(1, 0, 6'h05, 8'h00, 0);
    a_req(0, 1, 6'h07, 8'h11, 0);
    a_req(1, 0, 6'h07, 8'h00, 0);
    a_req(1, 1, 6'h07, 8'h99, 0);
    a_req(1, 0, 6'h07, 8'h00, 0);

    for (int k = 0; k < 200; k++) begin
      op = int'($urandom_range(0, 15));
      if (op < 5)       a_req(1, 0, 6'($urandom), 8'h00, 1'($urandom));
      else if (op < 10) a_req(0, 1, 6'($urandom), 8'($urandom), 1'($urandom));
      else if (op < 13) a_load(6'($urandom), 8'($urandom));
      else if (op < 14) a_req(1, 1, 6'($urandom), 8'($urandom), 0);
      else              @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("a_drain", sbq.size(), 0);
    rst_a = 1'b1;
    @(negedge clk);
    a_reset_check();

    // Instance B: zero wait states, no clear sweep.
    rst_b = 1'b0;
    #1;
    chk("b_clearing", {31'd0, ifb.clearing}, 0);
    chk("b_load_ready", {31'd0, ifb.load_ready}, 1);
    ifb.load_valid = 1; ifb.load_adr = 6'h01; ifb.load_data = 8'h5A;
    @(negedge clk);
    ifb.load_adr = 6'h02; ifb.load_data = 8'hC3;
    @(negedge clk);
    ifb.load_valid = 0;
    ifb.rd_mem = 1; ifb.adr_bus = 6'h01;
    #1 chk("b_first_sample_ready", {31'd0, ifb.mem_ready}, 0);
    @(negedge clk);
    chk("b_ready1", {31'd0, ifb.mem_ready}, 1);
    chk("b_data1", {24'd0, ifb.data_bus_in}, 32'h5A);
    @(negedge clk);
    ifb.adr_bus = 6'h02;
    chk("b_done_req_ignored", {31'd0, ifb.mem_ready}, 0);
    @(negedge clk);
    chk("b_ready2", {31'd0, ifb.mem_ready}, 1);
    chk("b_data2", {24'd0, ifb.data_bus_in}, 32'hC3);
    ifb.rd_mem = 0;
    @(negedge clk);
    chk("b_ready_low", {31'd0, ifb.mem_ready}, 0);
    ifb.wr_mem = 1; ifb.adr_bus = 6'h30; ifb.data_bus_out = 8'h77;
    @(negedge clk);
    ifb.wr_mem = 0;
    chk("b_wr_ready", {31'd0, ifb.mem_ready}, 1);
    chk("b_wr_keeps_data", {24'd0, ifb.data_bus_in}, 32'hC3);
    @(negedge clk);
    ifb.rd_mem = 1; ifb.adr_bus = 6'h30;
    @(negedge clk);
    ifb.rd_mem = 0;
    chk("b_rd_back", {24'd0, ifb.data_bus_in}, 32'h77);

    // Instance C: three wait states, reset lands mid-access.
    rst_c = 1'b0;
    ifc.load_valid = 1; ifc.load_adr = 6'h20; ifc.load_data = 8'h42;
    @(negedge clk);
    ifc.load_valid = 0;
    ifc.wr_mem = 1; ifc.adr_bus = 6'h20; ifc.data_bus_out = 8'hFF;
    @(negedge clk);
    ifc.wr_mem = 0;
    chk("c_wait_ready0", {31'd0, ifc.mem_ready}, 0);
    @(negedge clk);
    chk("c_wait_ready1", {31'd0, ifc.mem_ready}, 0);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    chk("c_rst_data", {24'd0, ifc.data_bus_in}, 0);
    chk("c_rst_clearing", {31'd0, ifc.clearing}, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (ifc.mem_ready) n++;
      @(negedge clk);
    end
    chk("c_aborted_no_ready", n, 0);
    ifc.rd_mem = 1; ifc.adr_bus = 6'h20;
    @(negedge clk);
    ifc.rd_mem = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("c_rd_latency", {31'd0, ifc.mem_ready}, (i == 4) ? 1 : 0);
      if (i < 4) @(negedge clk);
    end
    chk("c_old_value_kept", {24'd0, ifc.data_bus_in}, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 WAIT_STATES  1  extra cycles before each access completes; legal range 0..7.
 CLEAR_ON_RESET  1  1 = zero all 64 locations after reset; 0 = leave contents as they are.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 clk  in  1  sole clock; all logic on the rising edge.
 reset  in  1  synchronous, active-high reset.
 adr_bus  in  6  address from the CPU.
 rd_mem  in  1  CPU read request.
 wr_mem  in  1  CPU write request.
 data_bus_out  in  8  CPU write data.
 data_bus_in  out  8  read data to the CPU.
 mem_ready  out  1  one-cycle pulse when an access completes.
 bus_err  out  1  sticky error flag.
 clearing  out  1  high while the post-reset clear sweep runs.
 load_valid  in  1  preload write request.
 load_ready  out  1  preload accept.
 load_adr  in  6  preload address.
 load_data  in  8  preload data.

Function
REQ-003 Storage SHALL be 64 x 8 bits, addressed directly by the 6-bit address with no wrap logic.
REQ-004 The FSM SHALL have the states CLEAR, IDLE, WAIT and DONE.
REQ-005 On reset the FSM SHALL go to CLEAR when CLEAR_ON_RESET=1, else to IDLE.
REQ-006 CLEAR SHALL write 0x00 to addresses 0..63, one per cycle, using a 6-bit counter.
REQ-007 CLEAR SHALL move to IDLE after writing address 63, 64 cycles in total.
REQ-008 clearing SHALL equal (state==CLEAR).
REQ-009 In IDLE, a cycle with exactly one of rd_mem/wr_mem set SHALL latch the operation, adr_bus and data_bus_out.
REQ-010 After that latch, the FSM SHALL go to WAIT when WAIT_STATES>0, else to DONE.
REQ-011 A request SHALL be sampled only in IDLE; the requester need not hold it afterwards.
REQ-012 WAIT SHALL count WAIT_STATES cycles, then go to DONE.
REQ-013 The access SHALL be performed on the edge entering DONE.
REQ-014 A write SHALL commit the latched data on that edge.
REQ-015 A read SHALL load data_bus_in on that edge.
REQ-016 Latency: a request sampled in cycle T SHALL give mem_ready=1 in cycle T+1+WAIT_STATES.
REQ-017 mem_ready SHALL be high only in DONE; DONE SHALL always return to IDLE after one cycle.
REQ-018 data_bus_in SHALL hold the last read value until the next read completes; writes SHALL NOT change it.
REQ-019 Requests present in the DONE cycle SHALL be ignored, giving a back-to-back period of WAIT_STATES+2 cycles.
REQ-020 rd_mem and wr_mem high together in IDLE SHALL perform no access.
REQ-021 That simultaneous case SHALL set bus_err (sticky until reset), pass through WAIT/DONE with normal timing, and pulse mem_ready.
REQ-022 load_ready SHALL equal (state==IDLE) && !rd_mem && !wr_mem, so CPU requests take priority.
REQ-023 When load_valid && load_ready, load_data SHALL be written to load_adr on that edge.
REQ-024 A load SHALL NOT change state, data_bus_in or mem_ready.
REQ-025 Loads SHALL NOT be accepted during CLEAR, WAIT or DONE.
REQ-026 A read of the address being written in the same cycle SHALL NOT arise; the single-port write SHALL come from exactly one source per cycle (CLEAR, CPU or load).

Reset
REQ-027 When reset=1 at an edge, the FSM SHALL go to CLEAR or IDLE as per REQ-005.
REQ-028 On that edge data_bus_in=0x00, mem_ready=0, bus_err=0 and the wait counter=0.
REQ-029 After reset, load_ready SHALL be 0 while in CLEAR.
REQ-030 After reset, clearing SHALL be 1 when CLEAR_ON_RESET=1, else 0.
REQ-031 Reset in WAIT SHALL abort the access: no write commits and no mem_ready pulse.
REQ-032 Reset in CLEAR SHALL restart the sweep from address 0.
REQ-033 When CLEAR_ON_RESET=0, memory contents SHALL be unaffected by reset.

Structure
REQ-034 Package mem_pkg SHALL hold ADR_W=6, DATA_W=8, DEPTH=64 and the state enum type.
REQ-035 Sub-module mem_array SHALL be a 64x8 single-port array with synchronous write and combinational read.
REQ-036 mem_responder SHALL contain the FSM, the counters, write-source muxing and the output registers.

Verification
REQ-037 CLEAR_ON_RESET=1: reset, then wait. Required: clearing high exactly 64 cycles; afterwards a read of adr 0x3F returns 0x00.
REQ-038 WAIT_STATES=1: write 0xA5 to adr 0x12 sampled at T. Required: mem_ready at T+2; a following read returns 0xA5 with mem_ready 2 cycles after its sample.
REQ-039 WAIT_STATES=0: back-to-back reads of 0x01 and 0x02 held continuously. Required: mem_ready pulses are 2 cycles apart; the DONE-cycle request is ignored.
REQ-040 Load 0x3C to adr 0x05 while rd_mem=1 in IDLE. Required: load_ready=0 and the load is stalled; it is accepted in the next IDLE cycle with the CPU idle; a read of 0x05 returns 0x3C.
REQ-041 rd_mem=wr_mem=1 at adr 0x07 holding 0x11. Required: bus_err=1 and stays set; mem_ready pulses; 0x07 still reads 0x11; data_bus_in unchanged.
REQ-042 Write 0xFF to adr 0x20 with WAIT_STATES=3, reset asserted in WAIT, CLEAR_ON_RESET=0. Required: no mem_ready; adr 0x20 keeps its old value.
